// File: rtl/input_dispatch.sv
// Frame dispatcher: reads a frame from the upstream FIFO and forwards it over valid/ready.
// Optional NaN scrubbing is enabled by defining INPUT_DISPATCH_NAN_FILTER_EN.
module input_dispatch #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 12
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  start_i,
    input  logic [CNT_WIDTH-1:0]  frame_len_i,
    input  logic                  fifo_empty_i,
    output logic                  fifo_rd_en_o,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_last_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  nan_seen_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [CNT_WIDTH-1:0]  len_q, len_d;
    logic [CNT_WIDTH-1:0]  issued_q, issued_d;
    logic [CNT_WIDTH-1:0]  delivered_q, delivered_d;
    logic                  inflight_q;
    logic [1:0]            count_q, count_d;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;

    logic [DATA_WIDTH-1:0] in_word;
    logic [1:0]            avail;
    logic [1:0]            avail_after_pop;
    logic [CNT_WIDTH:0]    delivered_next;
    logic                  pop;
    logic                  start_accept;

    assign start_accept = (state_q == IDLE) && start_i;

`ifdef INPUT_DISPATCH_NAN_FILTER_EN
    logic in_is_nan;
    logic nan_seen_q;

    assign in_is_nan = (&fifo_data_i[DATA_WIDTH-2 -: 8]) && (|fifo_data_i[DATA_WIDTH-10:0]);
    assign in_word   = in_is_nan ? '0 : fifo_data_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            nan_seen_q <= 1'b0;
        end else if (start_accept) begin
            nan_seen_q <= 1'b0;
        end else if (inflight_q && in_is_nan) begin
            nan_seen_q <= 1'b1;
        end
    end

    assign nan_seen_o = nan_seen_q;
`else
    assign in_word    = fifo_data_i;
    assign nan_seen_o = 1'b0;
`endif

    // The word arriving from the FIFO sits logically behind the buffered entries and is
    // visible at the output directly when the buffer is empty.
    assign avail           = count_q + {1'b0, inflight_q};
    assign out_valid_o     = (avail != 2'd0);
    assign pop             = out_valid_o && out_ready_i;
    assign avail_after_pop = avail - {1'b0, pop};
    assign delivered_next  = {1'b0, delivered_q} + {{CNT_WIDTH{1'b0}}, 1'b1};
    assign out_last_o      = out_valid_o && (delivered_next == {1'b0, len_q});

    always_comb begin
        out_data_o = '0;
        if (count_q != 2'd0) begin
            out_data_o = buf0_q;
        end else if (inflight_q) begin
            out_data_o = in_word;
        end
    end

    // A new read keeps buffered + in-flight within two entries after this cycle's pop.
    assign fifo_rd_en_o = (state_q == RUN) && !fifo_empty_i && (issued_q < len_q) &&
                          (avail_after_pop < 2'd2);

    always_comb begin
        buf0_d  = buf0_q;
        buf1_d  = buf1_q;
        count_d = avail_after_pop;
        if (pop) begin
            if (count_q == 2'd2) begin
                buf0_d = buf1_q;
            end else if ((count_q == 2'd1) && inflight_q) begin
                buf0_d = in_word;
            end
        end else if (inflight_q) begin
            if (count_q == 2'd0) begin
                buf0_d = in_word;
            end else begin
                buf1_d = in_word;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        issued_d    = issued_q;
        delivered_d = delivered_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    len_d       = frame_len_i;
                    issued_d    = '0;
                    delivered_d = '0;
                    state_d     = (frame_len_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (fifo_rd_en_o) begin
                    issued_d = issued_q + CNT_WIDTH'(1);
                end
                if (pop) begin
                    delivered_d = delivered_q + CNT_WIDTH'(1);
                end
                if (pop && out_last_o) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            len_q       <= '0;
            issued_q    <= '0;
            delivered_q <= '0;
            inflight_q  <= 1'b0;
            count_q     <= 2'd0;
            buf0_q      <= '0;
            buf1_q      <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            delivered_q <= delivered_d;
            inflight_q  <= fifo_rd_en_o;
            count_q     <= count_d;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
        end
    end

    assign busy_o = (state_q == RUN);
    assign done_o = (state_q == DONE);

endmodule
